// File: rtl/lector_7seg_if.sv
// lector_7seg_if: multiplexed 7-segment bus as seen by the readback checker.
//   master = display side (drives anodes/segments, reads recovered digits)
//   slave  = lector_7seg (samples the bus, reports decoded digits)
// Optional macro LECTOR_7SEG_CONTEO_ERR_EN adds the cuenta_err error counter.
interface lector_7seg_if #(
   parameter int N_DIGITS = 4
);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   logic [N_DIGITS-1:0]   anodos;      // active-low anode selects
   logic [6:0]            segmentos;   // active-low segments, a = bit6 ... g = bit0
   logic [4*N_DIGITS-1:0] digitos;     // recovered nibbles, digit i at [4i+3:4i]
   logic [N_DIGITS-1:0]   validos;     // digit i holds a decoded value
   logic                  nuevo;       // one-cycle capture pulse
   logic [IDX_W-1:0]      indice;      // index of last captured digit
   logic                  error;       // one-cycle unknown-pattern pulse
`ifdef LECTOR_7SEG_CONTEO_ERR_EN
   logic [7:0]            cuenta_err;  // saturating count of error pulses

   modport master (output anodos, segmentos,
                   input  digitos, validos, nuevo, indice, error, cuenta_err);
   modport slave  (input  anodos, segmentos,
                   output digitos, validos, nuevo, indice, error, cuenta_err);
`else
   modport master (output anodos, segmentos,
                   input  digitos, validos, nuevo, indice, error);
   modport slave  (input  anodos, segmentos,
                   output digitos, validos, nuevo, indice, error);
`endif
endinterface

// File: rtl/lector_7seg.sv
// lector_7seg: watches a multiplexed active-low 7-segment bus and recovers the
// hex nibble shown on each digit once the {anodos,segmentos} pattern has been
// stable for STABLE_CYCLES extra samples. One capture per stable window.
// Optional macro LECTOR_7SEG_CONTEO_ERR_EN adds a saturating error counter.
module lector_7seg #(
   parameter int N_DIGITS      = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic           clk,
   input  logic           rst,
   lector_7seg_if.slave   bus
);

   localparam int         IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int         SAMPLE_W = N_DIGITS + 7;
   localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      ESPERA,     // idle after reset, no window seen yet
      CONTANDO,   // window open, counting identical samples
      CAPTURADO   // window already consumed
   } state_t;

   state_t                r_estado;
   logic [SAMPLE_W-1:0]   r_muestra;
   logic [7:0]            r_cnt;
   logic [4*N_DIGITS-1:0] r_digitos;
   logic [N_DIGITS-1:0]   r_validos;
   logic                  r_nuevo;
   logic                  r_error;
   logic [IDX_W-1:0]      r_indice;

   logic [SAMPLE_W-1:0]   w_entrada;
   logic                  w_igual;
   logic                  w_captura;
   logic                  w_conocido;
   logic                  w_blanco;
   logic [3:0]            w_nibble;
   logic [3:0]            w_num_bajos;
   logic [IDX_W-1:0]      w_pos;

   assign w_entrada = {bus.anodos, bus.segmentos};
   assign w_igual   = (w_entrada == r_muestra);
   assign w_blanco  = (bus.segmentos == 7'b111_1111);
   // The edge that brings cnt to STABLE_CYCLES while the window is open.
   assign w_captura = w_igual && (r_estado == CONTANDO) && (r_cnt == C_STABLE - 8'd1);

   // Segment pattern to nibble lookup; anything outside the table is unknown.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_conocido = 1'b1;
      w_nibble   = 4'h0;
      case (bus.segmentos)
         7'b000_0001: w_nibble = 4'h0;
         7'b100_1111: w_nibble = 4'h1;
         7'b001_0010: w_nibble = 4'h2;
         7'b000_0110: w_nibble = 4'h3;
         7'b100_1100: w_nibble = 4'h4;
         7'b010_0100: w_nibble = 4'h5;
         7'b010_0000: w_nibble = 4'h6;
         7'b000_1111: w_nibble = 4'h7;
         7'b000_0000: w_nibble = 4'h8;
         7'b000_0100: w_nibble = 4'h9;
         7'b000_1000: w_nibble = 4'hA;
         7'b110_0000: w_nibble = 4'hB;
         7'b011_0001: w_nibble = 4'hC;
         7'b100_0010: w_nibble = 4'hD;
         7'b011_0000: w_nibble = 4'hE;
         7'b011_1000: w_nibble = 4'hF;
         default:     w_conocido = 1'b0;
      endcase
   end

   // Count low anodes and remember the position of the (last) low one.
   always_comb begin
      w_num_bajos = 4'd0;
      w_pos       = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (!bus.anodos[i]) begin
            w_num_bajos = w_num_bajos + 4'd1;
            w_pos       = IDX_W'(i);
         end
      end
   end

   // Stability window FSM plus the capture action on the digit registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado  <= ESPERA;
         r_muestra <= '1;
         r_cnt     <= 8'd0;
         r_digitos <= '0;
         r_validos <= '0;
         r_nuevo   <= 1'b0;
         r_error   <= 1'b0;
         r_indice  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         r_muestra <= w_entrada;
         r_nuevo   <= 1'b0;
         r_error   <= 1'b0;
         if (!w_igual) begin
            r_cnt    <= 8'd0;
            r_estado <= CONTANDO;
         end else begin
            if (r_cnt < C_STABLE) r_cnt <= r_cnt + 8'd1;
            if (w_captura) begin
               r_estado <= CAPTURADO;
               // Ghosted or blanked-out anodes give no usable digit.
               if (w_num_bajos == 4'd1) begin
                  if (w_conocido) begin
                     r_digitos[{w_pos, 2'b00} +: 4] <= w_nibble;
                     r_validos[w_pos]               <= 1'b1;
                     r_indice                       <= w_pos;
                     r_nuevo                        <= 1'b1;
                  end else if (w_blanco) begin
                     r_validos[w_pos] <= 1'b0;
                  end else begin
                     r_validos[w_pos] <= 1'b0;
                     r_indice         <= w_pos;
                     r_error          <= 1'b1;
                  end
               end
            end
         end
      end
   end

`ifdef LECTOR_7SEG_CONTEO_ERR_EN
   logic [7:0] r_cuenta_err;
   logic       w_err_captura;

   assign w_err_captura = w_captura && (w_num_bajos == 4'd1) && !w_conocido && !w_blanco;

   // Saturating count of unknown-pattern captures, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cuenta_err <= 8'd0;
      end else if (w_err_captura && (r_cuenta_err != 8'hFF)) begin
         r_cuenta_err <= r_cuenta_err + 8'd1;
      end
   end

   assign bus.cuenta_err = r_cuenta_err;
`endif

   assign bus.digitos = r_digitos;
   assign bus.validos = r_validos;
   assign bus.nuevo   = r_nuevo;
   assign bus.error   = r_error;
   assign bus.indice  = r_indice;

endmodule

// File: tb/tb_lector_7seg.sv
// tb_lector_7seg: directed self-checking bench for lector_7seg
// (N_DIGITS=4, STABLE_CYCLES=3). Honours LECTOR_7SEG_CONTEO_ERR_EN.
module tb_lector_7seg;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int total = 0;
   int bad   = 0;

   int n_nuevo = 0;
   int n_err   = 0;
   int n_both  = 0;
   int idx_q[$];

   lector_7seg_if #(.N_DIGITS(4)) bus ();

   lector_7seg #(.N_DIGITS(4), .STABLE_CYCLES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, sampling 1 ns after each and tallying pulses.
   task automatic hold(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (bus.nuevo === 1'b1) begin
            n_nuevo++;
            idx_q.push_back(int'(bus.indice));
         end
         if (bus.error === 1'b1) n_err++;
         if (bus.nuevo === 1'b1 && bus.error === 1'b1) n_both++;
      end
   endtask

   task automatic clear_counts();
      n_nuevo = 0;
      n_err   = 0;
      idx_q.delete();
   endtask

   task automatic drive(input logic [3:0] an, input logic [6:0] sg);
      bus.anodos    = an;
      bus.segmentos = sg;
   endtask

   initial begin
      logic [7:0] orden;

      drive(4'b1111, 7'b111_1111);
      hold(2);
      check("rst_digitos", 32'(bus.digitos), 32'h0);
      check("rst_validos", 32'(bus.validos), 32'h0);
      check("rst_nuevo",   32'(bus.nuevo),   32'h0);
      check("rst_indice",  32'(bus.indice),  32'h0);
      check("rst_error",   32'(bus.error),   32'h0);
`ifdef LECTOR_7SEG_CONTEO_ERR_EN
      check("rst_cuenta",  32'(bus.cuenta_err), 32'h0);
`endif
      rst = 1'b0;
      hold(2);

      // Single digit "2" on digit 0: capture after the fourth edge only.
      clear_counts();
      drive(4'b1110, 7'b001_0010);
      hold(3);
      check("d2_early",    32'(n_nuevo), 32'd0);
      hold(1);
      check("d2_nuevo",    32'(bus.nuevo),   32'h1);
      check("d2_digitos",  32'(bus.digitos), 32'h0002);
      check("d2_validos",  32'(bus.validos), 32'h1);
      check("d2_indice",   32'(bus.indice),  32'h0);
      hold(6);
      check("d2_once",     32'(n_nuevo),   32'd1);
      check("d2_cleared",  32'(bus.nuevo), 32'h0);

      // Four-digit scan showing 3 B F 0.
      clear_counts();
      drive(4'b0111, 7'b000_0110); hold(8);
      drive(4'b1011, 7'b110_0000); hold(8);
      drive(4'b1101, 7'b011_1000); hold(8);
      drive(4'b1110, 7'b000_0001); hold(8);
      check("scan_pulses", 32'(n_nuevo), 32'd4);
      orden = 8'h00;
      if (idx_q.size() == 4)
         orden = {idx_q[0][1:0], idx_q[1][1:0], idx_q[2][1:0], idx_q[3][1:0]};
      check("scan_orden",   32'(orden),       32'hE4);
      check("scan_digitos", 32'(bus.digitos), 32'h3BF0);
      check("scan_validos", 32'(bus.validos), 32'hF);
      check("scan_err",     32'(n_err),       32'd0);

      // Unknown pattern on digit 1.
      clear_counts();
      drive(4'b1101, 7'b111_0111); hold(8);
      check("unk_err",     32'(n_err),       32'd1);
      check("unk_nuevo",   32'(n_nuevo),     32'd0);
      check("unk_indice",  32'(bus.indice),  32'h1);
      check("unk_validos", 32'(bus.validos), 32'hD);
      check("unk_digitos", 32'(bus.digitos), 32'h3BF0);
`ifdef LECTOR_7SEG_CONTEO_ERR_EN
      check("unk_cuenta",  32'(bus.cuenta_err), 32'd1);
`endif

      // Blank on digit 0: invalidates without a pulse, nibble kept.
      clear_counts();
      drive(4'b1110, 7'b111_1111); hold(8);
      check("blank_pulses",  32'(n_nuevo + n_err), 32'd0);
      check("blank_validos", 32'(bus.validos), 32'hC);
      check("blank_digitos", 32'(bus.digitos), 32'h3BF0);

      // Two anodes low, then none low: nothing changes.
      clear_counts();
      drive(4'b1100, 7'b000_0001); hold(10);
      drive(4'b1111, 7'b000_0001); hold(10);
      check("multi_pulses",  32'(n_nuevo + n_err), 32'd0);
      check("multi_validos", 32'(bus.validos), 32'hC);
      check("multi_digitos", 32'(bus.digitos), 32'h3BF0);
      check("multi_indice",  32'(bus.indice),  32'h1);

      // Segments toggling every cycle never capture; settling captures after 4 edges.
      clear_counts();
      for (int t = 0; t < 20; t++) begin
         drive(4'b1110, (t % 2 == 1) ? 7'b100_1111 : 7'b000_0000);
         hold(1);
      end
      check("glitch_none", 32'(n_nuevo + n_err), 32'd0);
      drive(4'b1110, 7'b000_1111);
      hold(3);
      check("settle_early",   32'(n_nuevo),     32'd0);
      hold(1);
      check("settle_nuevo",   32'(bus.nuevo),   32'h1);
      check("settle_indice",  32'(bus.indice),  32'h0);
      check("settle_digitos", 32'(bus.digitos), 32'h3BF7);
      check("settle_validos", 32'(bus.validos), 32'hD);

`ifdef LECTOR_7SEG_CONTEO_ERR_EN
      // 300 more unknown windows push the counter into saturation.
      clear_counts();
      for (int w = 0; w < 300; w++) begin
         drive(4'b1101, 7'b111_0111); hold(4);
         drive(4'b1111, 7'b111_0111); hold(1);
      end
      check("sat_pulses", 32'(n_err),          32'd300);
      check("sat_cuenta", 32'(bus.cuenta_err), 32'd255);
`endif

      // Reset in the middle of an open window clears outputs at once.
      clear_counts();
      drive(4'b1011, 7'b000_0000);
      hold(2);
      #2 rst = 1'b1;
      #1;
      check("mid_digitos", 32'(bus.digitos), 32'h0);
      check("mid_validos", 32'(bus.validos), 32'h0);
      check("mid_indice",  32'(bus.indice),  32'h0);
      check("mid_nuevo",   32'(bus.nuevo),   32'h0);
      check("mid_error",   32'(bus.error),   32'h0);
`ifdef LECTOR_7SEG_CONTEO_ERR_EN
      check("mid_cuenta",  32'(bus.cuenta_err), 32'h0);
`endif
      #1 rst = 1'b0;
      hold(3);
      check("re_early",   32'(n_nuevo),     32'd0);
      hold(1);
      check("re_nuevo",   32'(bus.nuevo),   32'h1);
      check("re_digitos", 32'(bus.digitos), 32'h0800);
      check("re_validos", 32'(bus.validos), 32'h4);
      check("re_indice",  32'(bus.indice),  32'h2);

      check("never_both", 32'(n_both), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
